// File: rtl/pe_cfg_array_if.sv
// Bundles the configuration, weight, line-bus and psum ports of pe_cfg_array.
// The master side is the controller or bench; the slave side is the PE.
interface pe_cfg_array_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_LINES  = 32,
  parameter int WMEM_DEPTH = 64
);
  localparam int DW = $clog2(WMEM_DEPTH + 1);
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  logic                        clear;
  logic                        cfg_load;
  logic [DW-1:0]               cfg_delta;
  logic                        cfg_mode;
  logic                        cfg_relu6;
  logic                        cfg_szd_en;
  logic [LW-1:0]               line_sel;
  logic                        w_valid;
  logic                        w_ready;
  logic signed [DATA_W-1:0]    w_data;
  logic [NUM_LINES*DATA_W-1:0] ix_bus;
  logic                        ix_valid;
  logic                        stride_req;
  logic signed [DATA_W-1:0]    psum_in;
  logic                        psum_in_valid;
  logic signed [DATA_W-1:0]    psum_out;
  logic                        psum_out_valid;
  logic                        busy;

  modport master (
    output clear, cfg_load, cfg_delta, cfg_mode, cfg_relu6, cfg_szd_en, line_sel,
           w_valid, w_data, ix_bus, ix_valid, psum_in, psum_in_valid,
    input  w_ready, stride_req, psum_out, psum_out_valid, busy
  );

  modport slave (
    input  clear, cfg_load, cfg_delta, cfg_mode, cfg_relu6, cfg_szd_en, line_sel,
           w_valid, w_data, ix_bus, ix_valid, psum_in, psum_in_valid,
    output w_ready, stride_req, psum_out, psum_out_valid, busy
  );
endinterface

// File: rtl/pe_cfg_array.sv
// Configurable CNN processing element: weight load, activation fetch, 2-stage MAC/MAX pipeline.
// Optional macro PE_SAT_EN: saturating product truncation and accumulate instead of wrap.
module pe_cfg_array #(
  parameter int DATA_W     = 16,
  parameter int NUM_LINES  = 32,
  parameter int WMEM_DEPTH = 64,
  parameter int FRAC_SHIFT = 16,
  parameter int RELU6_VAL  = 6
) (
  input logic           clk,
  input logic           rst_n,
  pe_cfg_array_if.slave bus
);
  localparam int DW = $clog2(WMEM_DEPTH + 1);
  localparam int AW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic signed [DATA_W-1:0] RELU6 = DATA_W'(RELU6_VAL);

  logic [1:0]               state;
  logic [DW-1:0]            delta_q;
  logic [DW-1:0]            delta_in;
  logic [DW-1:0]            last_idx;
  logic                     mode_q;
  logic                     relu6_q;
  logic                     szd_q;
  logic [AW-1:0]            wa;
  logic [AW-1:0]            ra;
  logic signed [DATA_W-1:0] input_reg;
  logic signed [DATA_W-1:0] lane;
  logic signed [DATA_W-1:0] x_eff;
  logic signed [DATA_W-1:0] mem [WMEM_DEPTH];

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_w;
  logic signed [DATA_W-1:0] s1_x;
  logic signed [DATA_W-1:0] s1_psum;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] next_out;

  logic w_fire;
  logic ix_fire;
  logic step;

  assign w_fire  = (state == S_LOAD)  && bus.w_valid       && !bus.clear;
  assign ix_fire = (state == S_FETCH) && bus.ix_valid      && !bus.clear;
  assign step    = (state == S_RUN)   && bus.psum_in_valid && !bus.clear;

  assign last_idx = delta_q - DW'(1);
  assign lane     = bus.ix_bus[bus.line_sel*DATA_W +: DATA_W];
  assign x_eff    = (szd_q && input_reg <= 0) ? '0 : input_reg;

  // A zero delta still runs one step; oversize deltas are held to the RAM depth.
  always_comb begin
    delta_in = bus.cfg_delta;
    if (bus.cfg_delta == '0)
      delta_in = DW'(1);
    else if (bus.cfg_delta > DW'(WMEM_DEPTH))
      delta_in = DW'(WMEM_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      delta_q   <= '0;
      mode_q    <= 1'b0;
      relu6_q   <= 1'b0;
      szd_q     <= 1'b0;
      wa        <= '0;
      ra        <= '0;
      input_reg <= '0;
    end else if (bus.clear) begin
      state <= S_IDLE;
      wa    <= '0;
      ra    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cfg_load) begin
            delta_q <= delta_in;
            mode_q  <= bus.cfg_mode;
            relu6_q <= bus.cfg_relu6;
            szd_q   <= bus.cfg_szd_en;
            wa      <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_fire) begin
            if (DW'(wa) == last_idx) begin
              wa    <= '0;
              state <= S_FETCH;
            end else begin
              wa <= wa + AW'(1);
            end
          end
        end
        S_FETCH: begin
          if (ix_fire) begin
            input_reg <= lane;
            ra        <= '0;
            state     <= S_RUN;
          end
        end
        default: begin
          if (step) begin
            if (DW'(ra) == last_idx) state <= S_FETCH;
            else                     ra    <= ra + AW'(1);
          end
        end
      endcase
    end
  end

  // Weight RAM contents survive clear so only the LOAD handshake rewrites them.
  always_ff @(posedge clk) begin
    if (w_fire) mem[wa] <= bus.w_data;
  end

  always_comb begin
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   p;
    logic signed [DATA_W-1:0]   sum;
`ifdef PE_SAT_EN
    logic signed [2*DATA_W-1:0] shifted;
    logic signed [DATA_W:0]     sum_w;
    logic signed [2*DATA_W-1:0] pmax;
    logic signed [2*DATA_W-1:0] pmin;
`endif
    prod = (2*DATA_W)'(s1_w) * (2*DATA_W)'(s1_x);
`ifdef PE_SAT_EN
    pmax    = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    pmin    = ~pmax;
    shifted = prod >>> FRAC_SHIFT;
    if (shifted > pmax)      p = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < pmin) p = {1'b1, {(DATA_W-1){1'b0}}};
    else                     p = shifted[DATA_W-1:0];
    sum_w = {p[DATA_W-1], p} + {s1_psum[DATA_W-1], s1_psum};
    if (sum_w[DATA_W] != sum_w[DATA_W-1])
      sum = sum_w[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sum = sum_w[DATA_W-1:0];
`else
    p   = DATA_W'(prod >>> FRAC_SHIFT);
    sum = p + s1_psum;
`endif
    if (relu6_q && sum > RELU6) sum = RELU6;
    // Direct signed compare keeps MAX correct at the extremes of the range.
    next_out = mode_q ? sum : ((s1_x > s1_psum) ? s1_x : s1_psum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_w        <= '0;
      s1_x        <= '0;
      s1_psum     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid    <= step;
      out_valid_q <= s1_valid && !bus.clear;
      if (step) begin
        s1_w    <= mem[ra];
        s1_x    <= x_eff;
        s1_psum <= bus.psum_in;
      end
      if (s1_valid) out_q <= next_out;
    end
  end

  assign bus.w_ready        = (state == S_LOAD);
  assign bus.stride_req     = (state == S_FETCH);
  assign bus.busy           = (state != S_IDLE);
  assign bus.psum_out       = out_q;
  assign bus.psum_out_valid = out_valid_q;
endmodule

// File: tb/tb_pe_cfg_array.sv
// Scoreboard bench for pe_cfg_array: expected psums queued at issue, checked at output.
module tb_pe_cfg_array;
  localparam int DATA_W     = 16;
  localparam int NUM_LINES  = 32;
  localparam int WMEM_DEPTH = 64;
  localparam int FRAC_SHIFT = 0;
  localparam int RELU6_VAL  = 6;
  localparam int DW         = $clog2(WMEM_DEPTH + 1);
  localparam int LW         = $clog2(NUM_LINES);

  typedef struct {
    int value;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   assert_count = 0;
  int   fail_count   = 0;
  int   cyc          = 0;
  exp_t sb[$];

  int cur_mode, cur_relu6, cur_szd, cur_x, cur_delta, step_idx;
  int wts [WMEM_DEPTH];

  pe_cfg_array_if #(.DATA_W(DATA_W), .NUM_LINES(NUM_LINES), .WMEM_DEPTH(WMEM_DEPTH)) bus ();

  pe_cfg_array #(
    .DATA_W(DATA_W), .NUM_LINES(NUM_LINES), .WMEM_DEPTH(WMEM_DEPTH),
    .FRAC_SHIFT(FRAC_SHIFT), .RELU6_VAL(RELU6_VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int wrap_w(input longint v);
    logic signed [DATA_W-1:0] t;
    t = v[DATA_W-1:0];
    return int'(t);
  endfunction

  function automatic int clamp_w(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    lo = -(longint'(1) <<< (DATA_W - 1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic int model(input int w, input int x, input int psum);
    int     xe;
    longint prod, p, s;
    xe = (cur_szd != 0 && x <= 0) ? 0 : x;
    if (cur_mode == 0) return (xe > psum) ? xe : psum;
    prod = longint'(w) * longint'(xe);
    p    = prod >>> FRAC_SHIFT;
`ifdef PE_SAT_EN
    p = clamp_w(p);
    s = clamp_w(p + psum);
`else
    p = wrap_w(p);
    s = wrap_w(p + psum);
`endif
    if (cur_relu6 != 0 && s > RELU6_VAL) s = RELU6_VAL;
    return int'(s);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.psum_out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("psum_out", int'($signed(bus.psum_out)), e.value);
        checkOutput("latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.clear         = 1'b0;
    bus.cfg_load      = 1'b0;
    bus.cfg_delta     = '0;
    bus.cfg_mode      = 1'b0;
    bus.cfg_relu6     = 1'b0;
    bus.cfg_szd_en    = 1'b0;
    bus.line_sel      = '0;
    bus.w_valid       = 1'b0;
    bus.w_data        = '0;
    bus.ix_bus        = '0;
    bus.ix_valid      = 1'b0;
    bus.psum_in       = '0;
    bus.psum_in_valid = 1'b0;
  endtask

  task automatic configure(input int delta, input int mode, input int relu6, input int szd);
    cur_mode  = mode;
    cur_relu6 = relu6;
    cur_szd   = szd;
    cur_delta = (delta == 0) ? 1 : ((delta > WMEM_DEPTH) ? WMEM_DEPTH : delta);
    bus.cfg_delta  = DW'(delta);
    bus.cfg_mode   = mode[0];
    bus.cfg_relu6  = relu6[0];
    bus.cfg_szd_en = szd[0];
    bus.cfg_load   = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    checkOutput("w_ready_load", int'(bus.w_ready), 1);
  endtask

  task automatic load_weights(input int n);
    for (int i = 0; i < n; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DATA_W'(wts[i]);
      tick();
    end
    bus.w_valid = 1'b0;
    checkOutput("stride_req_fetch", int'(bus.stride_req), 1);
  endtask

  task automatic fetch(input int lane_idx, input int value);
    int n;
    n = 0;
    while (!bus.stride_req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("stride_req_wait", int'(bus.stride_req), 1);
    for (int i = 0; i < NUM_LINES; i++) bus.ix_bus[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    bus.ix_bus[lane_idx*DATA_W +: DATA_W] = DATA_W'(value);
    bus.line_sel = LW'(lane_idx);
    bus.ix_valid = 1'b1;
    cur_x        = value;
    step_idx     = 0;
    tick();
    bus.ix_valid = 1'b0;
    checkOutput("stride_req_run", int'(bus.stride_req), 0);
  endtask

  task automatic applyStimulus(input int psum, input int gap);
    exp_t e;
    repeat (gap) tick();
    bus.psum_in_valid = 1'b1;
    bus.psum_in       = DATA_W'(psum);
    e.value = model(wts[step_idx], cur_x, psum);
    e.due   = cyc + 2;
    sb.push_back(e);
    step_idx = (step_idx + 1) % cur_delta;
    tick();
    bus.psum_in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  task automatic abort_to_idle();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checkOutput("busy_after_clear", int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    init_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_w_ready", int'(bus.w_ready), 0);
    checkOutput("rst_stride_req", int'(bus.stride_req), 0);
    checkOutput("rst_out_valid", int'(bus.psum_out_valid), 0);
    checkOutput("rst_psum_out", int'($signed(bus.psum_out)), 0);
    rst_n = 1'b1;
    tick();

    // Basic MAC: weights {2,3,4}, input 10, psum 1 -> 21, 31, 41
    configure(3, 1, 0, 0);
    wts[0] = 2; wts[1] = 3; wts[2] = 4;
    load_weights(3);
    fetch(5, 10);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("stride_req_rise", int'(bus.stride_req), 1);
    drain();

    // Second activation with stalls between psum valids, weights reused
    fetch(2, -3);
    applyStimulus(5, 2);
    applyStimulus(-7, 0);
    applyStimulus(100, 3);
    drain();
    abort_to_idle();

    configure(1, 1, 1, 0);
    wts[0] = 1;
    load_weights(1);
    fetch(7, 10);
    applyStimulus(0, 0);
    drain();
    abort_to_idle();

    // Zero delta behaves as one step; SZD gates the negative input
    configure(0, 1, 0, 1);
    wts[0] = 7;
    load_weights(1);
    fetch(0, -5);
    applyStimulus(3, 0);
    drain();
    abort_to_idle();

    configure(1, 0, 0, 0);
    wts[0] = 123;
    load_weights(1);
    fetch(31, 32767);
    applyStimulus(-32768, 0);
    fetch(1, -4);
    applyStimulus(-9, 0);
    drain();
    abort_to_idle();

    configure(1, 1, 0, 0);
    wts[0] = 10;
    load_weights(1);
    fetch(3, 10);
    applyStimulus(32760, 0);
    drain();
    abort_to_idle();

    // Abort with a step in flight: its result must never appear
    configure(4, 1, 0, 0);
    wts[0] = 1; wts[1] = 2; wts[2] = 3; wts[3] = 4;
    load_weights(4);
    fetch(4, 2);
    bus.psum_in_valid = 1'b1;
    bus.psum_in       = DATA_W'(9);
    tick();
    bus.psum_in_valid = 1'b0;
    bus.clear         = 1'b1;
    tick();
    bus.clear = 1'b0;
    checkOutput("busy_abort", int'(bus.busy), 0);
    pulses = 0;
    repeat (6) begin
      tick();
      if (bus.psum_out_valid) pulses++;
    end
    checkOutput("no_out_after_clear", pulses, 0);

    configure(2, 1, 0, 0);
    wts[0] = 3; wts[1] = 5;
    load_weights(2);
    fetch(6, 4);
    applyStimulus(1, 0);
    drain();
    checkOutput("busy_mid_run", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", int'(bus.busy), 0);
    checkOutput("async_rst_psum_out", int'($signed(bus.psum_out)), 0);
    checkOutput("async_rst_out_valid", int'(bus.psum_out_valid), 0);
    checkOutput("async_rst_stride_req", int'(bus.stride_req), 0);
    checkOutput("async_rst_w_ready", int'(bus.w_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      if (bus.psum_out_valid) pulses++;
    end
    checkOutput("idle_after_reset", pulses, 0);
    checkOutput("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
